// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: registered round-robin arbiter sharing one L2 port
// between the L1 icache and dcache miss paths.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_pmem_*            - icache line-fill request / response
//   d_pmem_*            - dcache fill / writeback request / response
//   l2_mem_*            - registered command to the L2, line back
//   arb_busy            - high whenever a transaction is in flight
//   perf_*              - grant / conflict counters, present only
//                         when L2_ARB_PERF_CNT_EN is defined
module l2_rr_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
  input  logic                  l2_mem_resp,
  output logic                  arb_busy
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_i_grants,
  output logic [CNT_WIDTH-1:0]  perf_d_grants,
  output logic [CNT_WIDTH-1:0]  perf_conflicts
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state_q, state_d;

  logic                  last_d_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] ibuf_q;
  logic [LINE_WIDTH-1:0] dbuf_q;

  logic i_req, d_req;
  logic grant_d, grant_i;
  logic idle, busy_cmd;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // On a conflict the side that did not win last time goes first.
  assign grant_d = d_req & (~i_req | ~last_d_q);
  assign grant_i = i_req & ~grant_d;

  assign idle     = (state_q == IDLE);
  assign busy_cmd = (state_q == BUSY_I) |
                    (state_q == BUSY_D);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I: if (l2_mem_resp) state_d = RESP_I;
      BUSY_D: if (l2_mem_resp) state_d = RESP_D;
      RESP_I,
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ibuf_q   <= '0;
      dbuf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (idle && grant_d) begin
        last_d_q <= 1'b1;
        // read wins when both read and write are set
        wr_q     <= ~d_pmem_read;
        addr_q   <= d_pmem_address;
        wdata_q  <= d_pmem_wdata;
      end else if (idle && grant_i) begin
        last_d_q <= 1'b0;
        wr_q     <= 1'b0;
        addr_q   <= i_pmem_address;
      end
      if (state_q == BUSY_I && l2_mem_resp && !wr_q)
        ibuf_q <= l2_mem_rdata;
      if (state_q == BUSY_D && l2_mem_resp && !wr_q)
        dbuf_q <= l2_mem_rdata;
    end
  end

  assign l2_mem_read    = busy_cmd & ~wr_q;
  assign l2_mem_write   = busy_cmd & wr_q;
  assign l2_mem_address = addr_q;
  assign l2_mem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == RESP_I);
  assign d_pmem_resp  = (state_q == RESP_D);
  assign i_pmem_rdata = ibuf_q;
  assign d_pmem_rdata = dbuf_q;
  assign arb_busy     = ~idle;

`ifdef L2_ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = idle & i_req & d_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (idle && grant_i && !(&perf_i_grants))
        perf_i_grants <= perf_i_grants + CNT_WIDTH'(1);
      if (idle && grant_d && !(&perf_d_grants))
        perf_d_grants <= perf_d_grants + CNT_WIDTH'(1);
      if (conflict && !(&perf_conflicts))
        perf_conflicts <= perf_conflicts + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
